// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared types, flag indices and masks for alu_seq
package alu_pkg;

  typedef enum logic [3:0] {
    ADC = 4'd0, SBC = 4'd1, ORA = 4'd2, EOR = 4'd3, AND = 4'd4,
    ASL = 4'd5, LSR = 4'd6, ROL = 4'd7, ROR = 4'd8, CMP = 4'd9
  } op_t;

  typedef enum logic [1:0] {IDLE, BCD, DONE} state_t;

  // Bit positions inside the {n,v,z,c,hc} flag and write-enable vectors
  localparam int FN = 4;
  localparam int FV = 3;
  localparam int FZ = 2;
  localparam int FC = 1;
  localparam int FH = 0;

  localparam logic [4:0] WE_ALL = 5'b11111;
  localparam logic [4:0] WE_NZ  = 5'b10100;
  localparam logic [4:0] WE_NZC = 5'b10110;

  function automatic logic is_arith(input op_t o);
    return (o == ADC) || (o == SBC);
  endfunction

endpackage

// File: rtl/alu_bcd_digit.sv
// rtl/alu_bcd_digit.sv - one BCD digit add/subtract with decimal correction
module alu_bcd_digit (
  input  logic [3:0] ad,
  input  logic [3:0] bd,
  input  logic       cin,
  input  logic       sub,
  output logic [3:0] s,
  output logic       cout
);

  logic [4:0] w_sum;
  logic [4:0] w_dif;

  assign w_sum = {1'b0, ad} + {1'b0, bd} + {4'b0000, cin};
  // Five-bit difference: bit 4 set means the digit went negative (borrow)
  assign w_dif = {1'b0, ad} - {1'b0, bd} - {4'b0000, ~cin};

  always_comb begin
    s    = 4'h0;
    cout = 1'b0;
    if (sub) begin
      if (w_dif[4]) begin
        s    = w_dif[3:0] - 4'd6;
        cout = 1'b0;
      end else begin
        s    = w_dif[3:0];
        cout = 1'b1;
      end
    end else begin
      if (w_sum > 5'd9) begin
        s    = w_sum[3:0] + 4'd6;
        cout = 1'b1;
      end else begin
        s    = w_sum[3:0];
        cout = 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - registered 6502-style ALU with iterative BCD ADC/SBC
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  op_t              op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic             dec,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             n,
  output logic             v,
  output logic             z,
  output logic             c,
  output logic             hc,
  output logic [4:0]       flag_we
);

  localparam int NDIG = WIDTH / 4;
  localparam int IW   = $clog2(NDIG);
  localparam int M    = WIDTH - 1;

  state_t           r_state;
  logic             r_in_ready, r_out_valid;
  logic [WIDTH-1:0] r_a, r_b, r_y;
  logic [4:0]       r_flags, r_flag_we;
  logic [IW-1:0]    r_idx;
  logic             r_sub, r_carry, r_v, r_hc;

  logic [WIDTH:0]   w_add, w_sub, w_cmp;
  logic             w_v_add, w_v_sub;
  logic [WIDTH-1:0] w_y, w_nz_src, w_dec_y;
  logic             w_c, w_v, w_hc;
  logic [4:0]       w_we, w_flags;
  logic [3:0]       w_ad, w_bd, w_s;
  logic             w_cout, w_last;

  assign w_add   = {1'b0, a} + {1'b0, b}  + (WIDTH+1)'(ci);
  assign w_sub   = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(ci);
  assign w_cmp   = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1'b1);
  assign w_v_add = ~(a[M] ^ b[M]) & (a[M] ^ w_add[M]);
  assign w_v_sub =  (a[M] ^ b[M]) & (a[M] ^ w_sub[M]);

  always_comb begin
    w_y  = '0;
    w_c  = 1'b0;
    w_v  = 1'b0;
    w_hc = 1'b0;
    w_we = 5'b00000;
    case (op)
      ADC: begin w_y = w_add[M:0]; w_c = w_add[WIDTH]; w_v = w_v_add;
                 w_hc = w_add[4] ^ a[4] ^ b[4]; w_we = WE_ALL; end
      SBC: begin w_y = w_sub[M:0]; w_c = w_sub[WIDTH]; w_v = w_v_sub;
                 w_hc = w_sub[4] ^ a[4] ^ ~b[4]; w_we = WE_ALL; end
      ORA: begin w_y = a | b; w_we = WE_NZ; end
      EOR: begin w_y = a ^ b; w_we = WE_NZ; end
      AND: begin w_y = a & b; w_we = WE_NZ; end
      ASL: begin w_y = {a[M-1:0], 1'b0}; w_c = a[M]; w_we = WE_NZC; end
      LSR: begin w_y = {1'b0, a[M:1]};   w_c = a[0]; w_we = WE_NZC; end
      ROL: begin w_y = {a[M-1:0], ci};   w_c = a[M]; w_we = WE_NZC; end
      ROR: begin w_y = {ci, a[M:1]};     w_c = a[0]; w_we = WE_NZC; end
      CMP: begin w_y = a; w_c = w_cmp[WIDTH]; w_we = WE_NZC; end
      default: ;
    endcase
    // Compare reports n/z of the difference while passing A through
    w_nz_src = (op == CMP) ? w_cmp[M:0] : w_y;
  end

  assign w_flags = {w_nz_src[M], w_v, ~|w_nz_src, w_c, w_hc};

  assign w_ad   = r_a[{r_idx, 2'b00} +: 4];
  assign w_bd   = r_b[{r_idx, 2'b00} +: 4];
  assign w_last = (r_idx == IW'(NDIG - 1));

  alu_bcd_digit u_digit (
    .ad   (w_ad),
    .bd   (w_bd),
    .cin  (r_carry),
    .sub  (r_sub),
    .s    (w_s),
    .cout (w_cout)
  );

  always_comb begin
    w_dec_y = r_y;
    w_dec_y[{r_idx, 2'b00} +: 4] = w_s;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_y         <= '0;
      r_flags     <= 5'b00000;
      r_flag_we   <= 5'b00000;
      r_a         <= '0;
      r_b         <= '0;
      r_idx       <= '0;
      r_sub       <= 1'b0;
      r_carry     <= 1'b0;
      r_v         <= 1'b0;
      r_hc        <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (in_valid) begin
          r_in_ready <= 1'b0;
          if (dec && is_arith(op)) begin
            r_a     <= a;
            r_b     <= b;
            r_sub   <= (op == SBC);
            r_carry <= ci;
            r_v     <= (op == SBC) ? w_v_sub : w_v_add;
            r_idx   <= '0;
            r_y     <= '0;
            r_state <= BCD;
          end else begin
            r_y         <= w_y;
            r_flags     <= w_flags & w_we;
            r_flag_we   <= w_we;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end
        end
        BCD: begin
          r_y     <= w_dec_y;
          r_carry <= w_cout;
          if (r_idx == '0) r_hc <= w_cout;
          if (w_last) begin
            // Digit 0 was handled in an earlier cycle, so r_hc already holds its carry
            r_flags     <= {w_dec_y[M], r_v, ~|w_dec_y, w_cout, r_hc};
            r_flag_we   <= WE_ALL;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        DONE: if (out_ready) begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign y         = r_y;
  assign n         = r_flags[FN];
  assign v         = r_flags[FV];
  assign z         = r_flags[FZ];
  assign c         = r_flags[FC];
  assign hc        = r_flags[FH];
  assign flag_we   = r_flag_we;

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - randomized self-checking bench for alu_seq against a behavioural model
module tb_alu_seq;
  import alu_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, in_valid, in_ready, ci, dec, out_valid, out_ready;
  op_t        op;
  logic [7:0] a, b, y;
  logic       n, v, z, c, hc;
  logic [4:0] flag_we;

  logic        in_valid16, in_ready16, ci16, dec16, out_valid16, out_ready16;
  op_t         op16;
  logic [15:0] a16, b16, y16;
  logic        n16, v16, z16, c16, hc16;
  logic [4:0]  we16;

  alu_seq #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .a(a), .b(b), .ci(ci), .dec(dec), .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .n(n), .v(v), .z(z), .c(c), .hc(hc), .flag_we(flag_we));

  alu_seq #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready16), .op(op16),
    .a(a16), .b(b16), .ci(ci16), .dec(dec16), .out_valid(out_valid16), .out_ready(out_ready16),
    .y(y16), .n(n16), .v(v16), .z(z16), .c(c16), .hc(hc16), .flag_we(we16));

  typedef struct {
    logic [15:0] y;
    logic [4:0]  fl;
    logic [4:0]  we;
    int          lat;
  } exp_t;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic exp_t model(input int w, input int o, input int av, input int bv,
                                 input int civ, input int decv);
    exp_t e;
    int mask, half, sa, sb, r, s, cy, yv, nzv;
    bit fn, fv, fz, fc, fh;
    mask = (1 << w) - 1;
    half = 1 << (w - 1);
    sa = (av >= half) ? av - (1 << w) : av;
    sb = (bv >= half) ? bv - (1 << w) : bv;
    yv = 0; fv = 0; fc = 0; fh = 0; e.we = 5'b00000;
    case (o)
      0: begin
        r = av + bv + civ; yv = r & mask; fc = (r > mask);
        fh = ((av & 15) + (bv & 15) + civ) > 15;
        r = sa + sb + civ; fv = (r >= half) || (r < -half);
        e.we = 5'b11111;
        if (decv != 0) begin
          cy = civ; yv = 0;
          for (int d = 0; d < w / 4; d++) begin
            s = ((av >> (4 * d)) & 15) + ((bv >> (4 * d)) & 15) + cy;
            if (s > 9) begin s = s + 6; cy = 1; end else cy = 0;
            yv = yv | ((s & 15) << (4 * d));
            if (d == 0) fh = (cy != 0);
          end
          fc = (cy != 0);
        end
      end
      1: begin
        r = av - bv - (1 - civ); yv = r & mask; fc = (r >= 0);
        fh = ((av & 15) - (bv & 15) - (1 - civ)) >= 0;
        r = sa - sb - (1 - civ); fv = (r >= half) || (r < -half);
        e.we = 5'b11111;
        if (decv != 0) begin
          cy = civ; yv = 0;
          for (int d = 0; d < w / 4; d++) begin
            s = ((av >> (4 * d)) & 15) - ((bv >> (4 * d)) & 15) - (1 - cy);
            if (s < 0) begin s = (s - 6) & 15; cy = 0; end else cy = 1;
            yv = yv | ((s & 15) << (4 * d));
            if (d == 0) fh = (cy != 0);
          end
          fc = (cy != 0);
        end
      end
      2: begin yv = av | bv; e.we = 5'b10100; end
      3: begin yv = av ^ bv; e.we = 5'b10100; end
      4: begin yv = av & bv; e.we = 5'b10100; end
      5: begin yv = (av << 1) & mask; fc = (av >= half); e.we = 5'b10110; end
      6: begin yv = av >> 1; fc = ((av & 1) != 0); e.we = 5'b10110; end
      7: begin yv = ((av << 1) | civ) & mask; fc = (av >= half); e.we = 5'b10110; end
      8: begin yv = (av >> 1) | (civ << (w - 1)); fc = ((av & 1) != 0); e.we = 5'b10110; end
      9: begin yv = av; fc = (av >= bv); e.we = 5'b10110; end
      default: ;
    endcase
    nzv = (o == 9) ? ((av - bv) & mask) : yv;
    fn = ((nzv & half) != 0);
    fz = (nzv == 0);
    e.y   = yv[15:0];
    e.fl  = {fn, fv, fz, fc, fh} & e.we;
    e.lat = (decv != 0 && o <= 1) ? w / 4 + 1 : 1;
    return e;
  endfunction

  // Scoreboard: expectation captured at every accepted handshake, checked every valid cycle
  exp_t q[$];
  int   qt[$];
  bit   seen = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      qt.delete();
      seen = 0;
    end else begin
      if (out_valid) begin
        chk("in_ready_in_done", in_ready, 0);
        if (q.size() == 0) chk("spurious_out_valid", out_valid, 0);
        else begin
          if (!seen) chk("latency", cyc - qt[0], q[0].lat);
          seen = 1;
          chk("y", y, q[0].y[7:0]);
          chk("flags", {n, v, z, c, hc}, q[0].fl);
          chk("flag_we", flag_we, q[0].we);
          if (out_ready) begin
            void'(q.pop_front());
            void'(qt.pop_front());
            seen = 0;
          end
        end
      end
      if (in_valid && in_ready) begin
        q.push_back(model(8, int'(op), int'(a), int'(b), int'(ci), int'(dec)));
        qt.push_back(cyc);
      end
    end
  end

  task automatic send(input logic [3:0] o, input logic [7:0] av, input logic [7:0] bv,
                      input logic civ, input logic decv, input int hold);
    int k;
    @(posedge clk); #1;
    op = op_t'(o); a = av; b = bv; ci = civ; dec = decv; in_valid = 1'b1; out_ready = 1'b0;
    k = 0;
    while (!in_ready && k < 50) begin @(posedge clk); #1; k++; end
    chk("accept_timeout", in_ready, 1);
    @(posedge clk); #1;
    if (hold > 0) begin op = ADC; a = ~av; b = bv + 8'd1; dec = 1'b0; end
    else in_valid = 1'b0;
    k = 0;
    while (!out_valid && k < 50) begin @(posedge clk); #1; k++; end
    chk("done_timeout", out_valid, 1);
    repeat (hold) begin @(posedge clk); #1; end
    out_ready = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic send16(input logic [3:0] o, input logic [15:0] av, input logic [15:0] bv,
                        input logic civ, input logic decv);
    int k, t0;
    exp_t e;
    e = model(16, int'(o), int'(av), int'(bv), int'(civ), int'(decv));
    @(posedge clk); #1;
    op16 = op_t'(o); a16 = av; b16 = bv; ci16 = civ; dec16 = decv;
    in_valid16 = 1'b1; out_ready16 = 1'b1;
    @(negedge clk);
    chk("u16_accept", in_ready16, 1);
    t0 = cyc;
    @(posedge clk); #1;
    in_valid16 = 1'b0;
    k = 0;
    do begin @(negedge clk); k++; end while (!out_valid16 && k < 20);
    chk("u16_valid", out_valid16, 1);
    chk("u16_latency", cyc - t0, e.lat);
    chk("u16_y", y16, e.y);
    chk("u16_flags", {n16, v16, z16, c16, hc16}, e.fl);
    chk("u16_we", we16, e.we);
    @(posedge clk); #1;
    out_ready16 = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    exp_t e;
    rst_n = 1'b0; in_valid = 1'b0; op = ADC; a = '0; b = '0; ci = 1'b0; dec = 1'b0; out_ready = 1'b0;
    in_valid16 = 1'b0; op16 = ADC; a16 = '0; b16 = '0; ci16 = 1'b0; dec16 = 1'b0; out_ready16 = 1'b0;

    // Hand-computed expectations anchoring the model
    e = model(8, 0, 'h50, 'h50, 0, 0);
    chk("m_adc_y", e.y, 16'h00A0); chk("m_adc_fl", e.fl, 5'b11000);
    chk("m_adc_we", e.we, 5'b11111); chk("m_adc_lat", e.lat, 1);
    e = model(8, 0, 'h58, 'h46, 1, 1);
    chk("m_dadc_y", e.y, 16'h0005); chk("m_dadc_c", e.fl[FC], 1);
    chk("m_dadc_hc", e.fl[FH], 1); chk("m_dadc_z", e.fl[FZ], 0); chk("m_dadc_lat", e.lat, 3);
    e = model(8, 1, 'h12, 'h21, 1, 1);
    chk("m_dsbc_y", e.y, 16'h0091); chk("m_dsbc_c", e.fl[FC], 0);
    e = model(16, 1, 'h1000, 'h0001, 1, 1);
    chk("m_dsbc16_y", e.y, 16'h0999); chk("m_dsbc16_c", e.fl[FC], 1); chk("m_dsbc16_lat", e.lat, 5);
    e = model(8, 8, 'h01, 0, 1, 0);
    chk("m_ror_y", e.y, 16'h0080); chk("m_ror_fl", e.fl, 5'b10010);
    e = model(8, 6, 'h01, 0, 0, 0);
    chk("m_lsr_y", e.y, 16'h0000); chk("m_lsr_fl", e.fl, 5'b00110); chk("m_lsr_we", e.we, 5'b10110);
    e = model(8, 9, 'h30, 'h30, 0, 0);
    chk("m_cmp_y", e.y, 16'h0030); chk("m_cmp_fl", e.fl, 5'b00110);

    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1); chk("rst_out_valid", out_valid, 0);
    chk("rst_y", y, 0); chk("rst_flags", {n, v, z, c, hc}, 0); chk("rst_flag_we", flag_we, 0);
    chk("rst16_in_ready", in_ready16, 1); chk("rst16_out_valid", out_valid16, 0);
    rst_n = 1'b1;

    send(4'd0, 8'h50, 8'h50, 1'b0, 1'b0, 0);
    send(4'd0, 8'h58, 8'h46, 1'b1, 1'b1, 1);
    send(4'd1, 8'h12, 8'h21, 1'b1, 1'b1, 0);
    send(4'd8, 8'h01, 8'h00, 1'b1, 1'b0, 2);
    send(4'd6, 8'h01, 8'h00, 1'b0, 1'b0, 0);
    send(4'd9, 8'h30, 8'h30, 1'b0, 1'b0, 4);
    send(4'd9, 8'h10, 8'h30, 1'b0, 1'b1, 0);
    send(4'd13, 8'h55, 8'hAA, 1'b1, 1'b0, 0);
    send(4'd0, 8'hFA, 8'hBC, 1'b1, 1'b1, 0);

    // Reset while the decimal op is mid-flight
    @(posedge clk); #1;
    op = ADC; a = 8'h99; b = 8'h01; ci = 1'b0; dec = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    chk("midrst_accept", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0; rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("midrst_in_ready", in_ready, 1); chk("midrst_out_valid", out_valid, 0);
    chk("midrst_y", y, 0); chk("midrst_flag_we", flag_we, 0);
    out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    out_ready = 1'b0;
    send(4'd0, 8'h27, 8'h35, 1'b0, 1'b1, 0);

    send16(4'd1, 16'h1000, 16'h0001, 1'b1, 1'b1);
    for (int i = 0; i < 20; i++)
      send16(4'($urandom % 10), 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));

    // Free-running random traffic with random backpressure
    for (int i = 0; i < 600; i++) begin
      @(posedge clk); #1;
      in_valid  = ($urandom % 4) != 0;
      op        = op_t'(4'($urandom % 12));
      a         = 8'($urandom);
      b         = 8'($urandom);
      ci        = 1'($urandom);
      dec       = 1'($urandom);
      out_ready = ($urandom % 3) != 0;
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("drained", q.size(), 0);
    chk("end_in_ready", in_ready, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
